// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the uart_tx_sched transmit scheduler.
package uart_tx_sched_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        S_RESYNC    = 3'd0,
        S_IDLE      = 3'd1,
        S_LAUNCH    = 3'd2,
        S_WAIT_ACT  = 3'd3,
        S_WAIT_DONE = 3'd4
    } seq_state_e;

endpackage

// File: rtl/uart_tx_sched_fifo.sv
// Byte FIFO for uart_tx_sched: power-of-two depth, push and pop may coincide.
module uart_tx_sched_fifo
    import uart_tx_sched_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              push_i,
    input  logic [BYTE_W-1:0] data_i,
    input  logic              pop_i,
    output logic [BYTE_W-1:0] data_o,
    output logic [CW-1:0]     count_o
);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;

    // Storage array; contents are invalidated by the pointer/count reset.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally; count is unchanged when push and pop coincide.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/uart_tx_sched.sv
// Multi-requester scheduler feeding a single uart_tx instance.
// Optional: define UART_TX_SCHED_PRIO_EN to give requester 0 strict priority
// over a round-robin among requesters 1..NUM_REQ-1.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned FIFO_DEPTH = 16,
    localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset_n,
    input  logic [NUM_REQ-1:0]        i_Req_DV,
    input  logic [BYTE_W*NUM_REQ-1:0] i_Req_Byte,
    output logic [NUM_REQ-1:0]        o_Req_Ack,
    output logic                      o_Tx_DV,
    output logic [BYTE_W-1:0]         o_Tx_Byte,
    input  logic                      i_Tx_Active,
    input  logic                      i_Tx_Done,
    output logic [CW-1:0]             o_Fifo_Count,
    output logic                      o_Busy
);

    localparam int unsigned   LW       = $clog2(NUM_REQ);
    localparam logic [LW-1:0] LAST_RST = LW'(NUM_REQ - 1);

    logic [LW-1:0]      last_q, last_d, cand;
    logic               grant_vld;
    logic [NUM_REQ-1:0] req_ack;
    logic [BYTE_W-1:0]  push_byte, fifo_data;
    logic [CW-1:0]      fifo_count;
    logic               fifo_pop;
    seq_state_e         state_q, state_d;
    logic               tx_dv_q, tx_dv_d;
    logic [BYTE_W-1:0]  tx_byte_q, tx_byte_d;

    // Arbiter: at most one grant per cycle, only while the FIFO has room.
    always_comb begin
        req_ack   = '0;
        last_d    = last_q;
        grant_vld = 1'b0;
        cand      = '0;
        if (i_Reset_n && (fifo_count < CW'(FIFO_DEPTH))) begin
`ifdef UART_TX_SCHED_PRIO_EN
            if (i_Req_DV[0]) begin
                grant_vld  = 1'b1;
                req_ack[0] = 1'b1;
            end
            // Rotation stays inside 1..NUM_REQ-1, starting after last_q.
            for (int unsigned k = 1; k < NUM_REQ; k++) begin
                if (32'(last_q) + k > NUM_REQ - 1) begin
                    cand = LW'(32'(last_q) + k - (NUM_REQ - 1));
                end else begin
                    cand = LW'(32'(last_q) + k);
                end
                if (!grant_vld && i_Req_DV[cand]) begin
                    grant_vld     = 1'b1;
                    req_ack[cand] = 1'b1;
                    last_d        = cand;
                end
            end
`else
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                if (32'(last_q) + k >= NUM_REQ) begin
                    cand = LW'(32'(last_q) + k - NUM_REQ);
                end else begin
                    cand = LW'(32'(last_q) + k);
                end
                if (!grant_vld && i_Req_DV[cand]) begin
                    grant_vld     = 1'b1;
                    req_ack[cand] = 1'b1;
                    last_d        = cand;
                end
            end
`endif
        end
    end

    // Select the granted requester's byte for the FIFO write.
    always_comb begin
        push_byte = '0;
        for (int unsigned n = 0; n < NUM_REQ; n++) begin
            if (req_ack[n]) begin
                push_byte = i_Req_Byte[BYTE_W*n +: BYTE_W];
            end
        end
    end

    // Round-robin pointer; reset value makes requester 0 (or 1 in priority mode) win first.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            last_q <= LAST_RST;
        end else begin
            last_q <= last_d;
        end
    end

    uart_tx_sched_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_Clock),
        .rst_n_i (i_Reset_n),
        .push_i  (grant_vld),
        .data_i  (push_byte),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .count_o (fifo_count)
    );

    // Sequencer next-state: one frame outstanding; DV is only raised on entry to S_LAUNCH.
    always_comb begin
        state_d   = state_q;
        tx_byte_d = tx_byte_q;
        tx_dv_d   = 1'b0;
        fifo_pop  = 1'b0;
        case (state_q)
            S_RESYNC: begin
                if (!i_Tx_Active) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (fifo_count != '0) begin
                    fifo_pop  = 1'b1;
                    tx_byte_d = fifo_data;
                    tx_dv_d   = 1'b1;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_ACT;
            end
            S_WAIT_ACT: begin
                if (i_Tx_Active) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_RESYNC;
            end
        endcase
    end

    // Sequencer registers; reset lands in S_RESYNC since uart_tx itself is not reset.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q   <= S_RESYNC;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    // Waiting out a foreign frame in S_RESYNC is not counted as busy.
    assign o_Busy       = (fifo_count != '0) ||
                          (state_q inside {S_LAUNCH, S_WAIT_ACT, S_WAIT_DONE});
    assign o_Req_Ack    = req_ack;
    assign o_Tx_DV      = tx_dv_q;
    assign o_Tx_Byte    = tx_byte_q;
    assign o_Fifo_Count = fifo_count;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched with a behavioural uart_tx stand-in.
module tb_uart_tx_sched;

    localparam int NR    = 4;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b1;
    logic [NR-1:0]   req_dv   = '0;
    logic [8*NR-1:0] req_byte = '0;
    logic [NR-1:0]   ack;
    logic            tx_dv;
    logic [7:0]      tx_byte;
    logic [CW-1:0]   fifo_count;
    logic            busy;

    logic u_active     = 1'b0;
    logic u_done       = 1'b0;
    logic force_active = 1'b0;
    logic tx_active;
    int   u_cnt        = 0;
    int   frame_len    = 6;
    logic [7:0] sent_q[$];

    int total = 0;
    int bad   = 0;

    assign tx_active = u_active | force_active;
    always #5 clk = ~clk;

    uart_tx_sched #(.NUM_REQ(NR), .FIFO_DEPTH(DEPTH)) dut (
        .i_Clock      (clk),
        .i_Reset_n    (rst_n),
        .i_Req_DV     (req_dv),
        .i_Req_Byte   (req_byte),
        .o_Req_Ack    (ack),
        .o_Tx_DV      (tx_dv),
        .o_Tx_Byte    (tx_byte),
        .i_Tx_Active  (tx_active),
        .i_Tx_Done    (u_done),
        .o_Fifo_Count (fifo_count),
        .o_Busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // uart_tx stand-in: accepts DV when idle, stays active frame_len cycles, pulses done.
    always @(posedge clk) begin
        u_done <= 1'b0;
        if (u_active) begin
            if (u_cnt <= 1) begin
                u_active <= 1'b0;
                u_done   <= 1'b1;
            end else begin
                u_cnt <= u_cnt - 1;
            end
        end else if (tx_dv === 1'b1) begin
            u_active <= 1'b1;
            u_cnt    <= frame_len;
            sent_q.push_back(tx_byte);
        end
    end

    // Reference grant: first requester with DV scanning upward from last+1.
    function automatic logic [NR-1:0] exp_ack(input logic [NR-1:0] dv, input int cnt,
                                              input int last, input logic rn);
        logic [NR-1:0] r;
        int i;
        r = '0;
        if (!rn || cnt >= DEPTH) return r;
`ifdef UART_TX_SCHED_PRIO_EN
        if (dv[0]) begin
            r[0] = 1'b1;
            return r;
        end
        for (int k = 1; k < NR; k++) begin
            i = 1 + ((last - 1 + k) % (NR - 1));
            if (dv[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
`else
        for (int k = 1; k <= NR; k++) begin
            i = (last + k) % NR;
            if (dv[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
`endif
        return r;
    endfunction

    // Model: queue of accepted bytes plus a single send credit.
    logic [7:0] mq[$];
    int         m_last  = NR - 1;
    bit         m_free  = 1'b0;
    bit         m_out   = 1'b0;
    bit         m_dvexp = 1'b0;
    logic [7:0] m_byte  = 8'h00;
    logic [NR-1:0] m_a;
    bit         m_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_last  = NR - 1;
            m_free  = 1'b0;
            m_out   = 1'b0;
            m_dvexp = 1'b0;
        end else begin
            m_a     = exp_ack(req_dv, mq.size(), m_last, 1'b1);
            m_pop   = m_free && (mq.size() != 0);
            m_dvexp = 1'b0;
            if (m_pop) begin
                m_byte  = mq.pop_front();
                m_dvexp = 1'b1;
                m_free  = 1'b0;
                m_out   = 1'b1;
            end else if (!m_free && !m_out && !tx_active) begin
                m_free = 1'b1;
            end else if (m_out && u_done) begin
                m_out  = 1'b0;
                m_free = 1'b1;
            end
            for (int i = 0; i < NR; i++) begin
                if (m_a[i]) begin
                    mq.push_back(req_byte[8*i +: 8]);
`ifdef UART_TX_SCHED_PRIO_EN
                    if (i != 0) m_last = i;
`else
                    m_last = i;
`endif
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("ack", ack, exp_ack(req_dv, mq.size(), m_last, rst_n));
        check("count", fifo_count, mq.size());
        check("busy", busy, (mq.size() != 0) || m_out);
        check("tx_dv", tx_dv, m_dvexp);
        if (m_dvexp) check("tx_byte", tx_byte, m_byte);
        if (tx_dv === 1'b1) check("dv_while_active", tx_active, 1'b0);
    end

    int   dv_seen = 0;
    bit   log_en  = 1'b0;
    int   ack_log[$];
    logic [NR-1:0] acked = '0;
    bit   drv_on  = 1'b0;
    int   drv_pct = 0;

    always @(negedge clk) begin
        if (tx_dv === 1'b1) dv_seen++;
        acked = ack;
        if (log_en) begin
            for (int i = 0; i < NR; i++) if (ack[i]) ack_log.push_back(i);
        end
    end

    // Random requesters: DV held until acked, then re-drawn.
    always @(posedge clk) begin
        #1;
        if (drv_on) begin
            for (int n = 0; n < NR; n++) begin
                if (acked[n] || !req_dv[n]) begin
                    req_dv[n]          = ($urandom_range(99) < drv_pct);
                    req_byte[8*n +: 8] = 8'($urandom);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_quiet(input string tag);
        int i;
        for (i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (!busy && !u_active && !u_done) break;
        end
        check(tag, i < 6000, 1'b1);
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic send_one(input int n, input logic [7:0] b);
        int i;
        req_dv[n]          = 1'b1;
        req_byte[8*n +: 8] = b;
        for (i = 0; i < 500; i++) begin
            @(negedge clk);
            if (ack[n]) break;
        end
        check("send_ack_in_time", i < 500, 1'b1);
        step();
        req_dv[n] = 1'b0;
    endtask

    initial begin
        int base;
        int i;
        #1;
        rst_n  = 1'b0;
        req_dv = '1;
        repeat (3) @(negedge clk);
        check("rst_ack", ack, 4'b0000);
        check("rst_tx_dv", tx_dv, 1'b0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy, 1'b0);
        step();
        req_dv       = '0;
        force_active = 1'b1;
        rst_n        = 1'b1;

        // Reset while uart_tx appears busy: nothing launches until Active falls.
        dv_seen = 0;
        send_one(1, 8'hA5);
        repeat (200) @(negedge clk);
        check("resync_no_dv", dv_seen, 0);
        check("resync_count", fifo_count, 1);
        step();
        force_active = 1'b0;
        for (i = 0; i < 50 && sent_q.size() == 0; i++) @(negedge clk);
        check("resync_sent_n", sent_q.size(), 1);
        if (sent_q.size() > 0) check("resync_byte", sent_q[0], 8'hA5);
        wait_quiet("quiet_t1");

        // Single request into an idle system.
        req_dv[2]        = 1'b1;
        req_byte[23:16]  = 8'h3C;
        @(negedge clk);
        check("single_ack", ack, 4'b0100);
        step();
        req_dv[2] = 1'b0;
        @(negedge clk);
        check("single_dv_e0", tx_dv, 1'b0);
        @(negedge clk);
        check("single_dv_e1", tx_dv, 1'b1);
        check("single_byte", tx_byte, 8'h3C);
        @(negedge clk);
        check("single_dv_e2", tx_dv, 1'b0);
        wait_quiet("quiet_t2");
        check("single_sent", sent_q[$], 8'h3C);

        // All requesters valid: grants rotate 0,1,2,3 and bytes leave in that order.
        do_reset();
        base = sent_q.size();
        ack_log.delete();
        req_byte = {8'h13, 8'h12, 8'h11, 8'h10};
        log_en   = 1'b1;
        req_dv   = '1;
        for (i = 0; i < 100 && ack_log.size() < 8; i++) @(negedge clk);
        step();
        req_dv = '0;
        log_en = 1'b0;
        for (int k = 0; k < 8; k++)
            check("rr_order", (ack_log.size() > k) ? ack_log[k] : -1, k % 4);
        wait_quiet("quiet_t3");
        for (int k = 0; k < 4; k++)
            check("rr_sent", (sent_q.size() > base + k) ? sent_q[base + k] : 8'hxx, 8'h10 + k);

        // Full FIFO holds requesters off; the first pop frees a slot next cycle.
        frame_len = 300;
        req_byte  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_dv    = '1;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fifo_count == 5'd16) break;
        end
        check("full_count", fifo_count, 16);
        check("full_no_ack", ack, 4'b0000);
        for (i = 0; i < 500; i++) begin
            @(negedge clk);
            if (fifo_count == 5'd15) break;
        end
        check("full_drop", fifo_count, 15);
        check("full_release_ack", ack != 0, 1'b1);
        check("full_release_onehot", $onehot(ack), 1'b1);
        step();
        req_dv    = '0;
        frame_len = 6;
        wait_quiet("quiet_t4");

`ifdef UART_TX_SCHED_PRIO_EN
        begin : prio_t
            int p0;
            int p3;
            p0 = 0;
            p3 = 0;
            do_reset();
            req_dv = 4'b1001;
            repeat (10) begin
                @(negedge clk);
                if (ack[0]) p0++;
                if (ack[3]) p3++;
            end
            check("prio_req0_acks", p0, 10);
            check("prio_req3_acks", p3, 0);
            step();
            req_dv[0] = 1'b0;
            @(negedge clk);
            check("prio_req3_after", ack, 4'b1000);
            step();
            req_dv = '0;
            wait_quiet("quiet_prio");
        end
`endif

        // Reset mid-frame with bytes queued: queue discarded, nothing more sent.
        frame_len = 100;
        for (int k = 0; k < 6; k++) send_one(1, 8'h60 + 8'(k));
        @(negedge clk);
        check("midrst_queued", fifo_count, 5);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_count", fifo_count, 0);
        check("midrst_busy", busy, 1'b0);
        step();
        step();
        rst_n     = 1'b1;
        frame_len = 6;
        base      = sent_q.size();
        dv_seen   = 0;
        for (i = 0; i < 200 && (u_active || u_done); i++) @(negedge clk);
        check("midrst_frame_end", i < 200, 1'b1);
        repeat (50) @(negedge clk);
        check("midrst_no_send", sent_q.size(), base);
        check("midrst_no_dv", dv_seen, 0);
        check("midrst_idle_busy", busy, 1'b0);
        step();

        // Randomized traffic, one reset in the middle.
        frame_len = $urandom_range(12, 3);
        drv_pct   = 40;
        drv_on    = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (c % 500 == 499) frame_len = $urandom_range(12, 3);
            if (c == 1500) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
        end
        drv_pct = 0;
        for (i = 0; i < 500 && req_dv != 0; i++) @(negedge clk);
        check("rand_drain", i < 500, 1'b1);
        step();
        drv_on = 1'b0;
        wait_quiet("quiet_rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
